// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues credit-limited imem requests and
// keeps a 2-entry in-order instruction queue; redirects flush and drop stale responses.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000,
  parameter int unsigned MAX_OUT  = 2
) (
  input  logic        CLK,
  input  logic        rst,
  input  logic        bubble,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Inst,
  output logic [31:0] Inst_foward,
  output logic        inst_valid,
  output logic [31:0] pc_id
);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] resp_pc_q, resp_pc_d;
  logic [31:0] ent0_dat_q, ent0_dat_d, ent0_pc_q, ent0_pc_d;
  logic [31:0] ent1_dat_q, ent1_dat_d, ent1_pc_q, ent1_pc_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [1:0]  out_q, out_d;
  logic [1:0]  drop_q, drop_d;

  logic        issue, rsp, pop, push;
  logic [1:0]  cnt_pop;
  logic [2:0]  credit_sum;
  logic        unused_rpc_lsb;

  assign unused_rpc_lsb = ^redirect_pc[1:0];

  // Queue slots plus in-flight requests never exceed the two queue entries.
  assign credit_sum = {1'b0, cnt_q} + {1'b0, out_q};
  assign imem_req   = !rst && (state_q == RUN) && !redirect_valid &&
                      (credit_sum < 3'd2) && ({30'b0, out_q} < MAX_OUT);
  assign imem_addr  = fetch_pc_q;

  // Responses arriving with nothing outstanding belong to a pre-reset request.
  assign rsp     = imem_rvalid && (out_q != 2'd0);
  assign issue   = imem_req && imem_gnt;
  assign pop     = (state_q == RUN) && (cnt_q != 2'd0) && !bubble && !redirect_valid;
  assign push    = (state_q == RUN) && rsp && !redirect_valid;
  assign cnt_pop = cnt_q - {1'b0, pop};

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    ent0_dat_d = ent0_dat_q;
    ent0_pc_d  = ent0_pc_q;
    ent1_dat_d = ent1_dat_q;
    ent1_pc_d  = ent1_pc_q;
    cnt_d      = cnt_q;
    drop_d     = drop_q;
    out_d      = out_q + {1'b0, issue} - {1'b0, rsp};

    if (redirect_valid) begin
      cnt_d      = 2'd0;
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      resp_pc_d  = {redirect_pc[31:2], 2'b00};
      drop_d     = out_q - {1'b0, rsp};
      state_d    = (drop_d != 2'd0) ? FLUSH : RUN;
    end else if (state_q == FLUSH) begin
      if (rsp) begin
        drop_d = drop_q - 2'd1;
      end
      if (drop_d == 2'd0) begin
        state_d = RUN;
      end
    end else begin
      if (issue) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      // Shift only when entry 1 is real so pc_id holds while the queue is empty.
      if (pop && (cnt_q == 2'd2)) begin
        ent0_dat_d = ent1_dat_q;
        ent0_pc_d  = ent1_pc_q;
      end
      if (push) begin
        if (cnt_pop == 2'd0) begin
          ent0_dat_d = imem_rdata;
          ent0_pc_d  = resp_pc_q;
        end else begin
          ent1_dat_d = imem_rdata;
          ent1_pc_d  = resp_pc_q;
        end
        resp_pc_d = resp_pc_q + 32'd4;
      end
      cnt_d = cnt_pop + {1'b0, push};
    end
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state_q    <= RUN;
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      ent0_dat_q <= NOP_INST;
      ent0_pc_q  <= RESET_PC;
      ent1_dat_q <= NOP_INST;
      ent1_pc_q  <= RESET_PC;
      cnt_q      <= 2'd0;
      out_q      <= 2'd0;
      drop_q     <= 2'd0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      ent0_dat_q <= ent0_dat_d;
      ent0_pc_q  <= ent0_pc_d;
      ent1_dat_q <= ent1_dat_d;
      ent1_pc_q  <= ent1_pc_d;
      cnt_q      <= cnt_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
    end
  end

  assign Inst        = (cnt_q != 2'd0) ? ent0_dat_q : NOP_INST;
  assign Inst_foward = (cnt_q == 2'd2) ? ent1_dat_q : NOP_INST;
  assign inst_valid  = (cnt_q != 2'd0);
  assign pc_id       = ent0_pc_q;

  a_no_overflow: assert property (@(posedge CLK) disable iff (rst) !(push && (cnt_pop == 2'd2)));
  a_out_bound:   assert property (@(posedge CLK) disable iff (rst) ({30'b0, out_q} <= MAX_OUT));

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: in-order memory model, expected-instruction scoreboard
// popped by a monitor on every queue pop, plus directed checks per scenario.
module tb_fetch_stage;

  localparam logic [31:0] KEY = 32'hDEAD_0000;

  logic        CLK;
  logic        rst;
  logic        bubble;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] Inst;
  logic [31:0] Inst_foward;
  logic        inst_valid;
  logic [31:0] pc_id;

  int checks   = 0;
  int failures = 0;
  int stepno   = 0;
  int lat      = 1;

  logic [31:0] pend_addr[$];
  int          pend_rdy[$];
  logic [63:0] exp_q[$];

  fetch_stage dut (
    .CLK            (CLK),
    .rst            (rst),
    .bubble         (bubble),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .Inst           (Inst),
    .Inst_foward    (Inst_foward),
    .inst_valid     (inst_valid),
    .pc_id          (pc_id)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (step %0d)", name, act, exp, stepno);
    end
  endtask

  // One cycle: drive inputs at negedge, model memory, record grants.
  task automatic step(input logic r, input logic bub, input logic redir,
                      input logic [31:0] rpc, input logic gnt);
    @(negedge CLK);
    rst            = r;
    bubble         = bub;
    redirect_valid = redir;
    redirect_pc    = rpc;
    imem_gnt       = gnt;
    imem_rvalid    = 1'b0;
    imem_rdata     = 32'h0;
    if (r) begin
      pend_addr.delete();
      pend_rdy.delete();
      exp_q.delete();
    end else if (pend_addr.size() != 0 && pend_rdy[0] <= stepno) begin
      imem_rvalid = 1'b1;
      imem_rdata  = pend_addr[0] ^ KEY;
      void'(pend_addr.pop_front());
      void'(pend_rdy.pop_front());
    end
    #1;
    if (imem_req && imem_gnt) begin
      pend_addr.push_back(imem_addr);
      pend_rdy.push_back(stepno + lat);
      exp_q.push_back({imem_addr, imem_addr ^ KEY});
    end
    if (redir) exp_q.delete();
    stepno++;
  endtask

  // Monitor: every head pop must match the oldest expected instruction.
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge CLK);
      #2;
      if (!rst && inst_valid && !bubble && !redirect_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL pop_unexpected: got pc %h inst %h expected no instruction", pc_id, Inst);
        end else begin
          e = exp_q.pop_front();
          chk("pop_pc", pc_id, e[63:32]);
          chk("pop_inst", Inst, e[31:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"},   {31'b0, imem_req},   32'h0);
    chk({tag, "_addr"},  imem_addr,           32'h0);
    chk({tag, "_inst"},  Inst,                32'h0);
    chk({tag, "_instf"}, Inst_foward,         32'h0);
    chk({tag, "_valid"}, {31'b0, inst_valid}, 32'h0);
    chk({tag, "_pcid"},  pc_id,               32'h0);
  endtask

  initial begin
    rst = 1'b1; bubble = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;

    step(1, 0, 0, 32'h0, 1);
    step(1, 0, 0, 32'h0, 1);
    chk_reset_outputs("rst");

    // Streaming fetch from RESET_PC, then fill the queue under bubble.
    step(0, 0, 0, 32'h0, 1);
    chk("release_req", {31'b0, imem_req}, 32'h1);
    repeat (7) step(0, 0, 0, 32'h0, 1);
    step(0, 1, 0, 32'h0, 1);
    for (int i = 0; i < 2; i++) begin
      step(0, 1, 0, 32'h0, 1);
      chk("full_inst",  Inst,                32'hDEAD_0010);
      chk("full_instf", Inst_foward,         32'hDEAD_0014);
      chk("full_pcid",  pc_id,               32'h0000_0010);
      chk("full_valid", {31'b0, inst_valid}, 32'h1);
      chk("full_req",   {31'b0, imem_req},   32'h0);
    end
    step(0, 0, 0, 32'h0, 1);
    lat = 3;
    step(0, 0, 0, 32'h0, 1);
    chk("unbub_inst",  Inst,        32'hDEAD_0014);
    chk("unbub_pcid",  pc_id,       32'h0000_0014);
    chk("unbub_instf", Inst_foward, 32'h0);

    // Redirect with two responses in flight.
    step(0, 0, 0, 32'h0, 1);
    step(0, 0, 1, 32'h0000_0103, 1);
    chk("redir_req", {31'b0, imem_req}, 32'h0);
    step(0, 0, 0, 32'h0, 1);
    chk("flush1_req", {31'b0, imem_req}, 32'h0);
    step(0, 0, 0, 32'h0, 1);
    chk("flush2_req", {31'b0, imem_req}, 32'h0);
    lat = 1;
    step(0, 0, 0, 32'h0, 1);
    chk("restart_req",  {31'b0, imem_req}, 32'h1);
    chk("restart_addr", imem_addr,         32'h0000_0100);
    step(0, 0, 0, 32'h0, 1);
    step(0, 0, 0, 32'h0, 1);
    chk("redir_valid", {31'b0, inst_valid}, 32'h1);
    chk("redir_pcid",  pc_id,               32'h0000_0100);
    chk("redir_inst",  Inst,                32'hDEAD_0100);

    // Grant withheld: request and address must hold.
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 32'h0, 0);
      chk("nognt_req",  {31'b0, imem_req}, 32'h1);
      chk("nognt_addr", imem_addr,         32'h0000_0108);
    end
    step(0, 0, 0, 32'h0, 1);
    step(0, 0, 0, 32'h0, 1);
    chk("gnt_adv_req",  {31'b0, imem_req}, 32'h1);
    chk("gnt_adv_addr", imem_addr,         32'h0000_010C);

    // Redirect coinciding with the only outstanding response, then PC wrap.
    step(0, 0, 1, 32'hFFFF_FFFC, 1);
    chk("wrap_redir_req", {31'b0, imem_req}, 32'h0);
    step(0, 0, 0, 32'h0, 1);
    chk("wrap_req",  {31'b0, imem_req}, 32'h1);
    chk("wrap_addr", imem_addr,         32'hFFFF_FFFC);
    step(0, 0, 0, 32'h0, 1);
    chk("wrap_next_req",  {31'b0, imem_req}, 32'h1);
    chk("wrap_next_addr", imem_addr,         32'h0000_0000);
    step(0, 0, 0, 32'h0, 1);
    chk("wrap_pcid", pc_id, 32'hFFFF_FFFC);
    chk("wrap_inst", Inst,  32'h2152_FFFC);

    // Asynchronous reset mid-cycle.
    step(0, 0, 0, 32'h0, 1);
    #2;
    rst = 1'b1;
    pend_addr.delete();
    pend_rdy.delete();
    exp_q.delete();
    #1;
    chk_reset_outputs("arst");
    step(1, 0, 0, 32'h0, 1);
    step(0, 0, 0, 32'h0, 1);
    chk("rerun_req",  {31'b0, imem_req}, 32'h1);
    chk("rerun_addr", imem_addr,         32'h0);
    repeat (10) step(0, 0, 0, 32'h0, 1);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step(0, 0, 0, 32'h0, 0);
    chk("drain_empty", exp_q.size(), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
